// File: rtl/reg_scoreboard_pkg.sv
// regfile_pkg: shared constants and types for the register scoreboard slice.
//   NUM_REGS  - number of architectural registers (power of two, >= 4)
//   ADDR_W    - register address width
//   ZERO_REG  - index of the hard-wired zero register (XZR), never tracked
//   CNT_W     - width of each per-register in-flight write counter
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG = NUM_REGS - 1;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  // Typed copies of the constants so comparisons stay width-matched.
  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);
  localparam sb_cnt_t   CNT_MAX   = '1;
  localparam sb_cnt_t   CNT_ONE   = sb_cnt_t'(1);

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue / writeback / source-query bundle of the scoreboard.
//   master modport - pipeline side: drives issue, writeback and rs queries,
//                    receives ready, write enables, busy, stall, pending, err
//   slave modport  - scoreboard side, the mirror image
interface reg_scoreboard_if;
  import regfile_pkg::*;

  logic                issue_valid;
  reg_addr_t           issue_addr;
  logic                issue_ready;
  logic                wb_valid;
  reg_addr_t           wb_addr;
  logic [NUM_REGS-1:0] we_onehot;
  reg_addr_t           rs1_addr;
  reg_addr_t           rs2_addr;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                stall;
  logic [NUM_REGS-1:0] pending;
  logic                err;

  modport master (
    output issue_valid, issue_addr, wb_valid, wb_addr, rs1_addr, rs2_addr,
    input  issue_ready, we_onehot, rs1_busy, rs2_busy, stall, pending, err
  );

  modport slave (
    input  issue_valid, issue_addr, wb_valid, wb_addr, rs1_addr, rs2_addr,
    output issue_ready, we_onehot, rs1_busy, rs2_busy, stall, pending, err
  );

endinterface

// File: rtl/reg_scoreboard_onehot_decode.sv
// onehot_decode: parametrised N-bit address to 2^N one-hot decoder with enable.
//   addr   - binary address
//   en     - when low the output is all zeros
//   onehot - bit addr set when en is high
module onehot_decode #(
  parameter int N = 5
) (
  input  logic [N-1:0]      addr,
  input  logic              en,
  output logic [(2**N)-1:0] onehot
);

  // A single indexed set replaces the old fixed 2:4/3:8 decoder tree.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-file write-enable decoder plus per-register
// in-flight write scoreboard for the hazard unit.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears all counts and err
//   sb    - reg_scoreboard_if.slave: issue (valid/addr/ready), writeback
//           (valid/addr), one-hot write enable, rs1/rs2 busy queries,
//           stall, pending vector and sticky err
// Optional macro SCOREBOARD_WB_BYPASS_EN: when defined, a source whose last
// pending write retires in the current cycle is reported not busy, matching
// a write-first register file.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  reg_scoreboard_if.slave    sb
);

  sb_cnt_t             cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                wb_acc;
  logic                same_reg;
  logic                issue_acc;
  logic                issue_drop;
  logic                underflow;
  logic                rs1_raw;
  logic                rs2_raw;

  // Writebacks to XZR are invisible: no write enable and no count change.
  // Issue and writeback to the same register cancel out, so the issue is
  // allowed even when that register's counter is saturated.
  always_comb begin
    wb_acc     = sb.wb_valid && (sb.wb_addr != ZERO_ADDR);
    same_reg   = sb.issue_valid && wb_acc && (sb.issue_addr == sb.wb_addr);
    sb.issue_ready = same_reg || (cnt[sb.issue_addr] != CNT_MAX);
    issue_acc  = sb.issue_valid && sb.issue_ready && (sb.issue_addr != ZERO_ADDR);
    issue_drop = sb.issue_valid && !sb.issue_ready;
    underflow  = wb_acc && !same_reg && (cnt[sb.wb_addr] == '0);
  end

  // The writeback decoder doubles as the register-file write enable.
  onehot_decode #(.N(ADDR_W)) u_dec_wb (
    .addr   (sb.wb_addr),
    .en     (wb_acc),
    .onehot (dec_vec)
  );

  onehot_decode #(.N(ADDR_W)) u_dec_issue (
    .addr   (sb.issue_addr),
    .en     (issue_acc),
    .onehot (inc_vec)
  );

  assign sb.we_onehot = dec_vec;

  // Per-register counters. Both strobes on one register leave it alone;
  // a decrement at zero is an underflow and is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Sticky error: dropped issue at saturation or writeback underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.err <= 1'b0;
    end else if (issue_drop || underflow) begin
      sb.err <= 1'b1;
    end
  end

  always_comb begin
    sb.pending = '0;
    for (int i = 0; i < NUM_REGS; i++) sb.pending[i] = (cnt[i] != '0);
  end

  // Busy from registered counts; XZR is never busy.
  always_comb begin
    rs1_raw = (sb.rs1_addr != ZERO_ADDR) && (cnt[sb.rs1_addr] != '0);
    rs2_raw = (sb.rs2_addr != ZERO_ADDR) && (cnt[sb.rs2_addr] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    sb.rs1_busy = rs1_raw && !(wb_acc && (sb.wb_addr == sb.rs1_addr) &&
                               (cnt[sb.rs1_addr] == CNT_ONE));
    sb.rs2_busy = rs2_raw && !(wb_acc && (sb.wb_addr == sb.rs2_addr) &&
                               (cnt[sb.rs2_addr] == CNT_ONE));
`else
    sb.rs1_busy = rs1_raw;
    sb.rs2_busy = rs2_raw;
`endif
    sb.stall = sb.rs1_busy || sb.rs2_busy || issue_drop;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised successor to the fixed 5:32 register write-enable decoder.
- Decodes the writeback address into a one-hot register-file write-enable vector, gated by `wb_valid`.
- Keeps a per-register count of in-flight writes, from issue (decode stage) to writeback (WB stage).
- Reports source-operand busy and stall to the hazard unit; the ARM zero register is handled specially.

Parameters:
- NUM_REGS, 32, number of architectural registers; must be a power of two, ≥4.
- ADDR_W, $clog2(NUM_REGS), register address width.
- ZERO_REG, NUM_REGS-1, index of the hard-wired zero register (XZR); never tracked or written.
- CNT_W, 2, per-register in-flight counter width; max count is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  combinational; 0 when the count at `issue_addr` is at max.
- wb_valid  in  1  a writeback retires this cycle (equivalent of the old RegWrite).
- wb_addr  in  ADDR_W  writeback destination register.
- we_onehot  out  NUM_REGS  combinational one-hot register-file write enable.
- rs1_addr  in  ADDR_W  source register 1 queried this cycle.
- rs2_addr  in  ADDR_W  source register 2 queried this cycle.
- rs1_busy  out  1  source 1 has pending writes.
- rs2_busy  out  1  source 2 has pending writes.
- stall  out  1  rs1_busy | rs2_busy | (issue_valid & ~issue_ready).
- pending  out  NUM_REGS  bit i = (count[i] != 0).
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, immediate): all counts = 0 and err = 0.
  - Hence pending = 0, rs1_busy = rs2_busy = 0, issue_ready = 1.
  - we_onehot depends only on inputs; it is 0 while wb_valid = 0.
  - Reset mid-operation discards all in-flight state; no recovery.
- we_onehot:
  - Bit wb_addr is 1 iff wb_valid = 1 and wb_addr != ZERO_REG; all other bits are 0.
  - Zero latency.
- Issue (rising edge):
  - Accepted when issue_valid & issue_ready & (issue_addr != ZERO_REG).
  - An accepted issue increments count[issue_addr].
  - issue_valid with issue_ready = 0 is dropped and sets err; the count is unchanged.
- Writeback (rising edge):
  - Accepted when wb_valid & (wb_addr != ZERO_REG).
  - An accepted writeback decrements count[wb_addr].
  - A writeback with count = 0 is ignored and sets err (underflow).
- Simultaneous issue and writeback:
  - Different registers: both updates apply.
  - Same register: count is unchanged, with no overflow or underflow check.
  - This case is accepted even at max count, so issue_ready is forced to 1 for it.
- ZERO_REG:
  - Count is stays at 0; pending[ZERO_REG] = 0.
  - Busy is 0 for any source query of ZERO_REG.
  - Issue and writeback to ZERO_REG never set err.
- Busy: rs*_busy = (count[rs*_addr] != 0), from registered state; combinational from rs*_addr.
- err: sticky; cleared only by reset.
- Counter width: saturation is prevented by issue_ready; wrap-around never occurs.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: rs*_busy is 0 in the cycle where wb_valid is 1, wb_addr = rs*_addr, and count = 1.
  - This is same-cycle retirement of the last pending write; it matches a write-first register file.
  - stall follows the bypassed busy.
- Undefined: busy reflects the registered count only.
  - The consumer stalls one extra cycle after the final writeback.

Decomposition:
- Package regfile_pkg holds:
  - NUM_REGS, ADDR_W, ZERO_REG, CNT_W.
  - typedef reg_addr_t, logic [ADDR_W-1:0].
  - typedef sb_cnt_t, logic [CNT_W-1:0].
- Sub-module onehot_decode: parametrised N-bit address to 2^N one-hot, with enable.
  - Instantiated for we_onehot and for per-register increment/decrement strobes.
  - Replaces the old fixed 2:4/3:8 tree.

Test Plan:
- Reset then idle:
  - Assert reset, then release.
  - Required: pending = 0, issue_ready = 1, err = 0, we_onehot = 0; rs1_addr = 5 gives rs1_busy = 0.
- Basic hazard:
  - Issue to reg 3; next cycle rs1_addr = 3 gives rs1_busy = 1 and stall = 1.
  - wb_valid with wb_addr = 3 gives we_onehot = 0x00000008.
  - The following cycle rs1_busy = 0 (bypass off), or 0 in the wb cycle itself (bypass on).
- Saturation:
  - Issue to reg 7 three times; count = 3, issue_ready = 0 at addr 7.
  - A 4th issue is dropped: err = 1, count stays 3.
  - Issue and wb to reg 7 in the same cycle at count 3 leaves count = 3 and err unchanged.
- Zero register:
  - Issue and wb to reg 31 repeatedly.
  - Required: pending[31] = 0, we_onehot = 0, rs2_addr = 31 gives rs2_busy = 0, err = 0.
- Underflow:
  - wb_valid to reg 10 with count = 0.
  - Required: we_onehot bit 10 = 1, count stays 0, err = 1 and sticks until reset.
- Async reset mid-flight:
  - Issue to regs 1 and 2, then pulse reset between clock edges.
  - Required: pending = 0 immediately, without waiting for a clock edge.
